// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small write FIFO.
// Bit timing uses a 16-tick-per-bit baud divider so it matches the
// 16x-oversampling receiver on the other end of the link.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BPS        = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_done
);

  localparam int DIVIDER_COUNT = CLK_FREQ / (BPS * 16);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BCW = (DIVIDER_COUNT > 1) ? $clog2(DIVIDER_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic [BCW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic             push;
  logic             pop;
  logic             baud_tick;
  logic             last_tick;

  // FIFO bookkeeping: a push is only honoured against the registered full
  // flag, so a pop in the same cycle never frees room for it.
  always_comb begin
    push     = tx_start & ~full_q;
    pop      = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    full_d   = (count_d == CW'(FIFO_DEPTH));
  end

  // Baud divider restarts on the pop cycle so the start bit gets a full period.
  always_comb begin
    baud_tick  = (baud_cnt_q == BCW'(DIVIDER_COUNT - 1));
    last_tick  = baud_tick && (tick_cnt_q == 4'd15);
    baud_cnt_d = baud_cnt_q + BCW'(1);
    if (pop || baud_tick) begin
      baud_cnt_d = '0;
    end
  end

  // Next-state and frame datapath for the serialiser FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (state_q != IDLE && baud_tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d    = fifo_mem_q[rd_ptr_q];
          tx_d       = 1'b0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START_BIT;
        end
      end
      START_BIT: begin
        if (last_tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (last_tick) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (last_tick) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus all control registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      baud_cnt_q <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      baud_cnt_q <= baud_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Outputs come straight from registers; busy covers queued bytes too.
  always_comb begin
    tx      = tx_q;
    tx_done = done_q;
    tx_full = full_q;
    tx_busy = (state_q != IDLE) || (count_q != '0);
  end

endmodule
